// File: rtl/seq_addsub_mul_alu_if.sv
// ALU handshake bundle between the calculator controller (master) and the
// sequential arithmetic responder (slave).
interface seq_addsub_mul_alu_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [1:0]       op_sel;
  logic             busy;
  logic             finish;
  logic [WIDTH-1:0] result;
  logic             overflow;
  logic             err;

  modport master (
    output start, op_a, op_b, op_sel,
    input  busy, finish, result, overflow, err
  );

  modport slave (
    input  start, op_a, op_b, op_sel,
    output busy, finish, result, overflow, err
  );
endinterface

// File: rtl/seq_addsub_mul_alu.sv
// Multi-cycle signed add/sub (CHUNK bits per cycle) and shift-add multiply.
// Define ALU_SAT_EN to saturate the result on signed overflow instead of wrapping.
module seq_addsub_mul_alu #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input logic                  clk,
  input logic                  reset,
  seq_addsub_mul_alu_if.slave  bus
);
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int PW     = 2 * WIDTH + 2;
  localparam int CW     = $clog2(WIDTH + 1);

  localparam logic [PW-1:0]    MAX_POS = {{(PW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic [PW-1:0]    MAX_NEG = MAX_POS + PW'(1);
  localparam logic [WIDTH-1:0] SAT_POS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SAT_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, ADDSUB, MUL, ERR} state_t;
  state_t state, state_next;

  logic [WIDTH-1:0]       a_reg, b_reg;
  logic [WIDTH-CHUNK-1:0] sum_reg;
  logic                   carry;
  logic                   sign_a, sign_b;
  logic [CW-1:0]          cnt;
  logic [PW-1:0]          mcand, prod;
  logic [WIDTH:0]         mplier;
  logic [WIDTH-1:0]       result_q;
  logic                   overflow_q, err_q, finish_q;

  logic [CHUNK:0]   chunk_sum;
  logic [WIDTH-1:0] sum_full, as_res, mul_res;
  logic [PW-1:0]    prod_full;
  logic             as_ovf, mul_ovf, neg, last_chunk, last_mul;
  logic [WIDTH:0]   ext_a, ext_b, mag_a, mag_b;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:
        if (bus.start) begin
          case (bus.op_sel)
            2'b00, 2'b01: state_next = ADDSUB;
            2'b10:        state_next = MUL;
            default:      state_next = ERR;
          endcase
        end
      ADDSUB:  if (last_chunk) state_next = IDLE;
      MUL:     if (last_mul)   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    ext_a = {bus.op_a[WIDTH-1], bus.op_a};
    ext_b = {bus.op_b[WIDTH-1], bus.op_b};
    mag_a = ext_a[WIDTH] ? -ext_a : ext_a;
    mag_b = ext_b[WIDTH] ? -ext_b : ext_b;

    // sum_reg collects finished chunks from the top down; the live chunk completes the word
    chunk_sum  = {1'b0, a_reg[CHUNK-1:0]} + {1'b0, b_reg[CHUNK-1:0]} + {{CHUNK{1'b0}}, carry};
    sum_full   = {chunk_sum[CHUNK-1:0], sum_reg};
    last_chunk = (cnt == CW'(NCHUNK - 1));
    // sign_b holds the sign of the effective addend (~b for sub), so one rule covers both
    as_ovf     = (sign_a == sign_b) && (sum_full[WIDTH-1] != sign_a);

    prod_full = prod + (mplier[0] ? mcand : '0);
    last_mul  = (cnt == CW'(WIDTH - 1));
    neg       = sign_a ^ sign_b;
    mul_ovf   = neg ? (prod_full > MAX_NEG) : (prod_full > MAX_POS);

`ifdef ALU_SAT_EN
    as_res  = as_ovf  ? (sign_a ? SAT_NEG : SAT_POS) : sum_full;
    mul_res = mul_ovf ? (neg ? SAT_NEG : SAT_POS)
                      : (neg ? -prod_full[WIDTH-1:0] : prod_full[WIDTH-1:0]);
`else
    as_res  = sum_full;
    mul_res = neg ? -prod_full[WIDTH-1:0] : prod_full[WIDTH-1:0];
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_reg      <= '0;
      b_reg      <= '0;
      sum_reg    <= '0;
      carry      <= 1'b0;
      sign_a     <= 1'b0;
      sign_b     <= 1'b0;
      cnt        <= '0;
      mcand      <= '0;
      prod       <= '0;
      mplier     <= '0;
      result_q   <= '0;
      overflow_q <= 1'b0;
      err_q      <= 1'b0;
      finish_q   <= 1'b0;
    end else begin
      finish_q <= 1'b0;
      case (state)
        IDLE:
          if (bus.start) begin
            a_reg      <= bus.op_a;
            b_reg      <= (bus.op_sel == 2'b01) ? ~bus.op_b : bus.op_b;
            carry      <= (bus.op_sel == 2'b01);
            sign_a     <= bus.op_a[WIDTH-1];
            sign_b     <= (bus.op_sel == 2'b01) ? ~bus.op_b[WIDTH-1] : bus.op_b[WIDTH-1];
            sum_reg    <= '0;
            cnt        <= '0;
            mcand      <= {{(PW-WIDTH-1){1'b0}}, mag_a};
            mplier     <= mag_b;
            prod       <= '0;
            overflow_q <= 1'b0;
            err_q      <= 1'b0;
          end
        ADDSUB: begin
          a_reg   <= a_reg >> CHUNK;
          b_reg   <= b_reg >> CHUNK;
          carry   <= chunk_sum[CHUNK];
          sum_reg <= sum_full[WIDTH-1:CHUNK];
          cnt     <= cnt + CW'(1);
          if (last_chunk) begin
            result_q   <= as_res;
            overflow_q <= as_ovf;
            finish_q   <= 1'b1;
          end
        end
        MUL: begin
          prod   <= prod_full;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + CW'(1);
          if (last_mul) begin
            result_q   <= mul_res;
            overflow_q <= mul_ovf;
            finish_q   <= 1'b1;
          end
        end
        default: begin
          result_q   <= '0;
          overflow_q <= 1'b0;
          err_q      <= 1'b1;
          finish_q   <= 1'b1;
        end
      endcase
    end
  end

  assign bus.busy     = (state != IDLE);
  assign bus.finish   = finish_q;
  assign bus.result   = result_q;
  assign bus.overflow = overflow_q;
  assign bus.err      = err_q;
endmodule

// File: tb/tb_seq_addsub_mul_alu.sv
// Directed bench for seq_addsub_mul_alu; expected values follow ALU_SAT_EN
// when the bench is compiled with that macro defined.
module tb_seq_addsub_mul_alu;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  seq_addsub_mul_alu_if #(.WIDTH(16)) bus ();
  seq_addsub_mul_alu #(.WIDTH(16), .CHUNK(4)) dut (.clk(clk), .reset(reset), .bus(bus));

  int checks = 0;
  int errors = 0;

`ifdef ALU_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  // Raise start, let the accept edge pass, then scramble operands.
  task automatic issue(input logic [1:0] sel, input logic [15:0] a, input logic [15:0] b);
    bus.start  = 1'b1;
    bus.op_sel = sel;
    bus.op_a   = a;
    bus.op_b   = b;
    @(posedge clk); #1;
    bus.start  = 1'b0;
    bus.op_a   = 16'($urandom);
    bus.op_b   = 16'($urandom);
    bus.op_sel = 2'($urandom);
  endtask

  // Counts edges until finish (lat=-1 on timeout) and samples where busy was high.
  task automatic wait_finish(output int lat, output int busy_n);
    lat    = 0;
    busy_n = bus.busy ? 1 : 0;
    while (1) begin
      @(posedge clk); #1;
      lat++;
      if (bus.finish) break;
      if (bus.busy) busy_n++;
      if (lat >= 40) begin lat = -1; break; end
    end
  endtask

  task automatic test_reset;
    bus.start = 1'b0; bus.op_a = '0; bus.op_b = '0; bus.op_sel = '0;
    #3;
    checks++;
    if ({bus.busy, bus.finish, bus.overflow, bus.err, bus.result} !== 20'h0) begin
      errors++;
      $display("FAIL reset_outputs got %h want 00000",
               {bus.busy, bus.finish, bus.overflow, bus.err, bus.result});
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_addsub;
    logic [1:0]  sel [8] = '{2'd0, 2'd1, 2'd0, 2'd0, 2'd1, 2'd1, 2'd0, 2'd0};
    logic [15:0] va  [8] = '{16'd100, 16'h7FFF, 16'h7FFF, 16'h8000, 16'h0005, 16'h8000, 16'h0FFF, 16'h0000};
    logic [15:0] vb  [8] = '{16'hFFE2, 16'hFFFF, 16'h0001, 16'hFFFF, 16'h0007, 16'h0001, 16'h0001, 16'h0000};
    logic [15:0] rw  [8] = '{16'h0046, 16'h8000, 16'h8000, 16'h7FFF, 16'hFFFE, 16'h7FFF, 16'h1000, 16'h0000};
    logic [15:0] rs  [8] = '{16'h0046, 16'h7FFF, 16'h7FFF, 16'h8000, 16'hFFFE, 16'h8000, 16'h1000, 16'h0000};
    logic        ov  [8] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    int lat, busy_n;
    logic [15:0] exp;
    for (int i = 0; i < 8; i++) begin
      issue(sel[i], va[i], vb[i]);
      wait_finish(lat, busy_n);
      exp = SAT ? rs[i] : rw[i];
      checks++;
      if (lat !== 4 || busy_n !== 4) begin
        errors++;
        $display("FAIL addsub_latency[%0d] got lat=%0d busy=%0d want 4/4", i, lat, busy_n);
      end
      checks++;
      if ({bus.result, bus.overflow, bus.err, bus.busy} !== {exp, ov[i], 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL addsub_result[%0d] got %h ovf=%b err=%b busy=%b want %h ovf=%b err=0 busy=0",
                 i, bus.result, bus.overflow, bus.err, bus.busy, exp, ov[i]);
      end
      @(posedge clk); #1;
      checks++;
      if (bus.finish !== 1'b0 || bus.result !== exp) begin
        errors++;
        $display("FAIL addsub_hold[%0d] got finish=%b result=%h want 0 %h", i, bus.finish, bus.result, exp);
      end
    end
  endtask

  task automatic test_mul;
    logic [15:0] va [10] = '{16'hFF85, 16'h8000, 16'h8000, 16'h012C, 16'h0000,
                             16'hFFFF, 16'h00B5, 16'hFF00, 16'h0100, 16'hFED4};
    logic [15:0] vb [10] = '{16'h002D, 16'h0001, 16'hFFFF, 16'h012C, 16'h0000,
                             16'hFFFF, 16'h00B5, 16'h0080, 16'h0080, 16'h012C};
    logic [15:0] rw [10] = '{16'hEA61, 16'h8000, 16'h8000, 16'h5F90, 16'h0000,
                             16'h0001, 16'h7FF9, 16'h8000, 16'h8000, 16'hA070};
    logic [15:0] rs [10] = '{16'hEA61, 16'h8000, 16'h7FFF, 16'h7FFF, 16'h0000,
                             16'h0001, 16'h7FF9, 16'h8000, 16'h7FFF, 16'h8000};
    logic        ov [10] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    int lat, busy_n;
    logic [15:0] exp;
    for (int i = 0; i < 10; i++) begin
      issue(2'b10, va[i], vb[i]);
      wait_finish(lat, busy_n);
      exp = SAT ? rs[i] : rw[i];
      checks++;
      if (lat !== 16 || busy_n !== 16) begin
        errors++;
        $display("FAIL mul_latency[%0d] got lat=%0d busy=%0d want 16/16", i, lat, busy_n);
      end
      checks++;
      if ({bus.result, bus.overflow, bus.err} !== {exp, ov[i], 1'b0}) begin
        errors++;
        $display("FAIL mul_result[%0d] got %h ovf=%b err=%b want %h ovf=%b err=0",
                 i, bus.result, bus.overflow, bus.err, exp, ov[i]);
      end
    end
  endtask

  task automatic test_err;
    int lat, busy_n;
    issue(2'b11, 16'h1234, 16'h5678);
    wait_finish(lat, busy_n);
    checks++;
    if (lat !== 1 || busy_n !== 1) begin
      errors++;
      $display("FAIL err_latency got lat=%0d busy=%0d want 1/1", lat, busy_n);
    end
    checks++;
    if ({bus.result, bus.overflow, bus.err} !== {16'h0000, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL err_result got %h ovf=%b err=%b want 0000 ovf=0 err=1", bus.result, bus.overflow, bus.err);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.finish !== 1'b0 || bus.err !== 1'b1) begin
      errors++;
      $display("FAIL err_hold got finish=%b err=%b want 0 1", bus.finish, bus.err);
    end
  endtask

  task automatic test_ignore_mid;
    int lat, busy_n;
    issue(2'b00, 16'd100, 16'hFFE2);
    @(posedge clk); #1;
    bus.start = 1'b1; bus.op_sel = 2'b11; bus.op_a = 16'h1234; bus.op_b = 16'h1111;
    @(posedge clk); #1;
    bus.start = 1'b0;
    wait_finish(lat, busy_n);
    checks++;
    if (lat !== 2) begin
      errors++;
      $display("FAIL ignore_latency got %0d remaining edges want 2", lat);
    end
    checks++;
    if ({bus.result, bus.overflow, bus.err} !== {16'h0046, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL ignore_result got %h ovf=%b err=%b want 0046 ovf=0 err=0", bus.result, bus.overflow, bus.err);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.finish !== 1'b0) begin
      errors++;
      $display("FAIL ignore_no_extra got busy=%b finish=%b want 0 0", bus.busy, bus.finish);
    end
  endtask

  task automatic test_back_to_back;
    int lat, busy_n;
    issue(2'b01, 16'h0005, 16'h0007);
    wait_finish(lat, busy_n);
    issue(2'b10, 16'h0003, 16'hFFFC);
    wait_finish(lat, busy_n);
    checks++;
    if (lat !== 16 || bus.result !== 16'hFFF4) begin
      errors++;
      $display("FAIL b2b_mul got lat=%0d result=%h want 16 FFF4", lat, bus.result);
    end
    issue(2'b11, 16'h0000, 16'h0000);
    wait_finish(lat, busy_n);
    checks++;
    if (lat !== 1 || bus.err !== 1'b1) begin
      errors++;
      $display("FAIL b2b_err got lat=%0d err=%b want 1 1", lat, bus.err);
    end
    issue(2'b00, 16'h0001, 16'h0002);
    wait_finish(lat, busy_n);
    checks++;
    if (lat !== 4 || {bus.result, bus.err} !== {16'h0003, 1'b0}) begin
      errors++;
      $display("FAIL b2b_add got lat=%0d result=%h err=%b want 4 0003 0", lat, bus.result, bus.err);
    end
  endtask

  task automatic test_reset_mid;
    int lat, busy_n;
    bit seen;
    issue(2'b10, 16'h0101, 16'h0003);
    repeat (7) @(posedge clk);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({bus.busy, bus.finish, bus.overflow, bus.err, bus.result} !== 20'h0) begin
      errors++;
      $display("FAIL reset_mid_outputs got %h want 00000",
               {bus.busy, bus.finish, bus.overflow, bus.err, bus.result});
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (bus.finish || bus.busy) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_quiet got activity=%b want 0", seen);
    end
    issue(2'b00, 16'h0001, 16'h0001);
    wait_finish(lat, busy_n);
    checks++;
    if (lat !== 4 || bus.result !== 16'h0002) begin
      errors++;
      $display("FAIL reset_mid_add got lat=%0d result=%h want 4 0002", lat, bus.result);
    end
  endtask

  initial begin
    test_reset();
    test_addsub();
    test_mul();
    test_err();
    test_ignore_mid();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
